sccb_master: RTL and testbench

- SCCB (I2C-like) initiator that configures the OV7670 camera's register file over SIOC/SIOD.
- It is the controlling end of the camera's serial control port; the camera acts as responder.
- Sits in the clk25 domain next to the capture logic. It accepts one register read or write command at a time and reports completion.
- The top level converts the drive-low output into the open-drain SIOD pad; SIOC is driven push-pull.

---
 rtl/sccb_master.sv | 273 +++++++++++++++++++++++++++
 tb/tb_sccb_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_master.sv
// rtl/sccb_master.sv - SCCB initiator for OV7670 register reads and writes
//
// Purpose: runs one register read or write at a time over SIOC/SIOD and
// pulses done on completion. Each bus position lasts one quarter-bit
// (QTR clocks). sioc and siod_drive_low are registered, so both change on
// the same edge that enters a new quarter.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_rd                1 = register read, 0 = register write
//   cmd_addr, cmd_wdata   register sub-address and write data
//   done                  one-cycle completion pulse
//   rdata                 read result, valid from done until the next accept
//   nack                  acknowledge error seen during the transaction
//   sioc                  SCCB clock, push-pull
//   siod_drive_low        1 = pull SIOD low, 0 = release
//   siod_in               synchronised SIOD pad level
//
// Optional feature macro: SCCB_ACK_CHECK_EN
//   defined   - the 9th bit of every transmitted byte is sampled; a high
//               level sets nack
//   undefined - the 9th bit is don't-care and nack is tied low
module sccb_master #(
   parameter int         CLK_HZ  = 25_000_000,
   parameter int         SCCB_HZ = 100_000,
   parameter logic [7:0] DEV_ID  = 8'h42
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rd,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       done,
   output logic [7:0] rdata,
   output logic       nack,
   output logic       sioc,
   output logic       siod_drive_low,
   input  logic       siod_in
);
   localparam int            QTR      = CLK_HZ / (4 * SCCB_HZ);
   localparam int            TW       = (QTR > 1) ? $clog2(QTR) : 1;
   localparam logic [TW-1:0] QTR_LAST = TW'(QTR - 1);

   typedef enum logic [2:0] {IDLE, START, BIT, STOP, GAP, DONE} state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    qtr_q, qtr_d;
   logic [3:0]    bit_q, bit_d;
   logic [1:0]    byte_q, byte_d;
   logic          phase2_q, phase2_d;
   logic          rd_q, rd_d;
   logic [7:0]    addr_q, addr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic [7:0]    rx_q, rx_d;
   logic [7:0]    rdata_q, rdata_d;
   logic          ready_q, ready_d;
   logic          done_q, done_d;
   logic          sioc_q, sioc_d;
   logic          drv_q, drv_d;
`ifdef SCCB_ACK_CHECK_EN
   logic          nack_q, nack_d;
`endif

   logic          tick;
   logic          q3_first;
   logic          rx_byte;
   logic          rx_byte_next;
   logic [1:0]    last_byte;
   logic [7:0]    tx_byte;
   logic [2:0]    tx_idx;

   assign tick      = (timer_q == '0);
   assign q3_first  = (qtr_q == 2'd3) && (timer_q == QTR_LAST);
   // The only byte the master receives is the second byte after the repeated START of a read.
   assign rx_byte   = rd_q && phase2_q && (byte_q == 2'd1);
   assign last_byte = rd_q ? 2'd1 : 2'd2;

   always_comb begin
      state_d  = state_q;
      timer_d  = tick ? QTR_LAST : timer_q - 1'b1;
      qtr_d    = qtr_q;
      bit_d    = bit_q;
      byte_d   = byte_q;
      phase2_d = phase2_q;
      rd_d     = rd_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rx_d     = rx_q;
      rdata_d  = rdata_q;
      ready_d  = ready_q;
      done_d   = 1'b0;
`ifdef SCCB_ACK_CHECK_EN
      nack_d   = nack_q;
`endif

      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (cmd_valid && ready_q) begin
               state_d  = START;
               timer_d  = QTR_LAST;
               qtr_d    = 2'd0;
               bit_d    = 4'd0;
               byte_d   = 2'd0;
               phase2_d = 1'b0;
               rd_d     = cmd_rd;
               addr_d   = cmd_addr;
               wdata_d  = cmd_wdata;
               ready_d  = 1'b0;
`ifdef SCCB_ACK_CHECK_EN
               nack_d   = 1'b0;
`endif
            end
         end
         START: begin
            if (tick) begin
               if (qtr_q == 2'd1) begin
                  state_d = BIT;
                  qtr_d   = 2'd0;
                  bit_d   = 4'd0;
                  byte_d  = 2'd0;
               end else begin
                  qtr_d = qtr_q + 2'd1;
               end
            end
         end
         BIT: begin
            if (q3_first) begin
               if (rx_byte && !bit_q[3])
                  rx_d = {rx_q[6:0], siod_in};
`ifdef SCCB_ACK_CHECK_EN
               if (!rx_byte && bit_q[3] && siod_in)
                  nack_d = 1'b1;
`endif
            end
            if (tick) begin
               if (qtr_q == 2'd3) begin
                  qtr_d = 2'd0;
                  if (bit_q == 4'd8) begin
                     bit_d = 4'd0;
                     if (byte_q == last_byte)
                        state_d = STOP;
                     else
                        byte_d = byte_q + 2'd1;
                  end else begin
                     bit_d = bit_q + 4'd1;
                  end
               end else begin
                  qtr_d = qtr_q + 2'd1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (qtr_q == 2'd3) begin
                  qtr_d = 2'd0;
                  if (rd_q && !phase2_q) begin
                     state_d = GAP;
                  end else begin
                     state_d = DONE;
                     done_d  = 1'b1;
                     if (rd_q)
                        rdata_d = rx_q;
                  end
               end else begin
                  qtr_d = qtr_q + 2'd1;
               end
            end
         end
         GAP: begin
            if (tick) begin
               if (qtr_q == 2'd3) begin
                  state_d  = START;
                  qtr_d    = 2'd0;
                  byte_d   = 2'd0;
                  phase2_d = 1'b1;
               end else begin
                  qtr_d = qtr_q + 2'd1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            timer_d = '0;
            ready_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // Bus levels for the position being entered, so the outputs stay registered.
      case (byte_d)
         2'd0:    tx_byte = phase2_d ? (DEV_ID | 8'h01) : DEV_ID;
         2'd1:    tx_byte = addr_d;
         default: tx_byte = wdata_d;
      endcase
      tx_idx       = 3'd7 - bit_d[2:0];
      rx_byte_next = rd_d && phase2_d && (byte_d == 2'd1);
      sioc_d       = 1'b1;
      drv_d        = 1'b0;
      case (state_d)
         START: drv_d = (qtr_d == 2'd1);
         BIT: begin
            sioc_d = qtr_d[1];
            // 9th bit and every bit of the received byte leave SIOD released.
            if (!bit_d[3] && !rx_byte_next)
               drv_d = ~tx_byte[tx_idx];
         end
         STOP: begin
            sioc_d = (qtr_d != 2'd0);
            drv_d  = !qtr_d[1];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         qtr_q    <= 2'd0;
         bit_q    <= 4'd0;
         byte_q   <= 2'd0;
         phase2_q <= 1'b0;
         rd_q     <= 1'b0;
         addr_q   <= 8'h00;
         wdata_q  <= 8'h00;
         rx_q     <= 8'h00;
         rdata_q  <= 8'h00;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         sioc_q   <= 1'b1;
         drv_q    <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
         nack_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         qtr_q    <= qtr_d;
         bit_q    <= bit_d;
         byte_q   <= byte_d;
         phase2_q <= phase2_d;
         rd_q     <= rd_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rx_q     <= rx_d;
         rdata_q  <= rdata_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         sioc_q   <= sioc_d;
         drv_q    <= drv_d;
`ifdef SCCB_ACK_CHECK_EN
         nack_q   <= nack_d;
`endif
      end
   end

   assign cmd_ready      = ready_q;
   assign done           = done_q;
   assign rdata          = rdata_q;
   assign sioc           = sioc_q;
   assign siod_drive_low = drv_q;
`ifdef SCCB_ACK_CHECK_EN
   assign nack           = nack_q;
`else
   assign nack           = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_master.sv
// tb/tb_sccb_master.sv - scoreboard bench for sccb_master with a camera responder model
`timescale 1ns/1ps
module tb_sccb_master;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_rd = 1'b0;
   logic [7:0] cmd_addr = 8'h00;
   logic [7:0] cmd_wdata = 8'h00;
   logic       cmd_ready;
   logic       done;
   logic [7:0] rdata;
   logic       nack;
   logic       sioc;
   logic       siod_drive_low;
   logic       siod_in;
   logic       resp_low = 1'b0;

`ifdef SCCB_ACK_CHECK_EN
   localparam logic ACK_EN = 1'b1;
`else
   localparam logic ACK_EN = 1'b0;
`endif
   localparam int WR_LAT = 7068;
   localparam int RD_LAT = 9920;

   // open-drain bus: either end can pull low
   assign siod_in = ~(siod_drive_low | resp_low);

   always #20 clk = ~clk;

   sccb_master dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .done(done), .rdata(rdata), .nack(nack),
      .sioc(sioc), .siod_drive_low(siod_drive_low), .siod_in(siod_in)
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct {
      logic        rd;
      logic [7:0]  rdata;
      logic        nack;
      int          latency;
      logic [31:0] bytes;
      int          nbytes;
      logic [3:0]  acks;
      int          starts;
      int          stops;
   } exp_t;

   exp_t sb[$];

   // ---------------- responder model and bus logger ----------------
   logic [31:0] lg_bytes = 0;
   int          lg_n = 0;
   logic [3:0]  lg_acks = 0;
   int          lg_starts = 0, lg_stops = 0, lg_tviol = 0;
   int          lg_plen = 0, lg_prev_low = 0;
   logic        lg_prev_sioc = 1'b1, lg_prev_bus = 1'b1, lg_bus;
   int          r_bit = 0, r_byte = 0;
   logic [7:0]  r_cur = 0;
   logic        r_isrd = 1'b0;
   logic [7:0]  rd_val = 8'h76;
   int          inject_byte = -1;

   always @(negedge clk) begin
      lg_bus = siod_in;
      if (sioc && lg_prev_sioc && lg_prev_bus && !lg_bus) begin
         lg_starts++;
         r_bit = 0; r_byte = 0; r_cur = 0; r_isrd = 1'b0;
      end
      if (sioc && lg_prev_sioc && !lg_prev_bus && lg_bus) lg_stops++;
      if (sioc && !lg_prev_sioc) begin
         if (r_bit < 8) begin
            r_cur = {r_cur[6:0], lg_bus};
            r_bit++;
         end else begin
            lg_bytes = {lg_bytes[23:0], r_cur};
            lg_n++;
            lg_acks = {lg_acks[2:0], lg_bus};
            if (r_byte == 0) r_isrd = r_cur[0];
            r_bit = 0;
            r_byte++;
         end
      end
      if (!sioc && lg_prev_sioc) begin
         resp_low = 1'b0;
         if (r_isrd && r_byte == 1) begin
            if (r_bit < 8) resp_low = ~rd_val[7 - r_bit];
         end else if (r_bit == 8) begin
            resp_low = (r_byte != inject_byte);
         end
      end
      if (!reset_n) resp_low = 1'b0;
      // phase lengths: bit halves are 124 clocks, the low quarter before STOP is 62
      if (sioc != lg_prev_sioc) begin
         if (!lg_prev_sioc) begin
            if (lg_plen != 124 && lg_plen != 62) lg_tviol++;
            lg_prev_low = lg_plen;
         end else if (lg_prev_low == 124 && lg_plen != 124) begin
            lg_tviol++;
         end
         lg_plen = 1;
      end else begin
         lg_plen++;
      end
      lg_prev_sioc = sioc;
      lg_prev_bus  = lg_bus;
      if (reset_n && cmd_valid && cmd_ready) begin
         lg_bytes = 0; lg_n = 0; lg_acks = 0;
         lg_starts = 0; lg_stops = 0; lg_tviol = 0; lg_prev_low = 0;
      end
   end

   // ---------------- scoreboard monitor ----------------
   int   ncyc = 0, acc_edge = 0, last_done = 0, done_cnt = 0, n_acc = 0;
   exp_t m_e;

   always @(negedge clk) begin
      ncyc++;
      if (done) begin
         done_cnt++;
         last_done = ncyc;
         chk("sb_nonempty_at_done", 32'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            m_e = sb.pop_front();
            chk("latency", ncyc - acc_edge, m_e.latency);
            if (m_e.rd) chk("rdata", rdata, m_e.rdata);
            chk("nack", nack, m_e.nack);
            chk("bus_bytes", lg_bytes, m_e.bytes);
            chk("bus_nbytes", lg_n, m_e.nbytes);
            chk("ack_bits", lg_acks, m_e.acks);
            chk("starts", lg_starts, m_e.starts);
            chk("stops", lg_stops, m_e.stops);
            chk("timing_violations", lg_tviol, 0);
            chk("ready_low_at_done", cmd_ready, 0);
         end
      end
      if (reset_n && cmd_valid && cmd_ready) begin
         acc_edge = ncyc + 1;
         n_acc++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic push_wr(input logic [7:0] a, input logic [7:0] d, input logic inj);
      exp_t e;
      e.rd = 1'b0; e.rdata = 8'h00; e.nack = inj & ACK_EN; e.latency = WR_LAT;
      e.bytes = {8'h00, 8'h42, a, d}; e.nbytes = 3; e.acks = {3'b000, inj};
      e.starts = 1; e.stops = 1;
      sb.push_back(e);
   endtask

   task automatic push_rd(input logic [7:0] a, input logic [7:0] v);
      exp_t e;
      e.rd = 1'b1; e.rdata = v; e.nack = 1'b0; e.latency = RD_LAT;
      e.bytes = {8'h42, a, 8'h43, v}; e.nbytes = 4; e.acks = 4'b0001;
      e.starts = 2; e.stops = 2;
      sb.push_back(e);
   endtask

   task automatic issue(input logic rd, input logic [7:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_rd = rd; cmd_addr = a; cmd_wdata = d;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int target, input int max);
      for (int i = 0; i < max && done_cnt < target; i++) begin
         @(negedge clk); #1;
      end
      if (done_cnt < target) chk("done_timeout", done_cnt, target);
   endtask

   int base_acc, base_done;

   initial begin
      repeat (5) @(posedge clk);
      #1;
      chk("rst_sioc", sioc, 1);
      chk("rst_siod_drive_low", siod_drive_low, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_done", done, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_nack", nack, 0);
      reset_n = 1'b1;

      // plain write
      push_wr(8'h12, 8'h80, 1'b0);
      issue(1'b0, 8'h12, 8'h80);
      wait_done(1, 12000);

      // read, responder returns 0x76
      rd_val = 8'h76;
      push_rd(8'h0A, 8'h76);
      issue(1'b1, 8'h0A, 8'h00);
      wait_done(2, 12000);

      // cmd_valid held through a write: second accept only after done
      base_acc = n_acc;
      push_wr(8'h33, 8'h5A, 1'b0);
      push_wr(8'h33, 8'h5A, 1'b0);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_addr = 8'h33; cmd_wdata = 8'h5A;
      wait_done(3, 12000);
      chk("accepts_while_busy", n_acc - base_acc, 1);
      for (int i = 0; i < 20 && n_acc < base_acc + 2; i++) begin
         @(negedge clk); #1;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("held_accept_count", n_acc - base_acc, 2);
      chk("held_accept_after_done", acc_edge - last_done, 2);
      wait_done(4, 12000);

      // reset during the address byte
      base_done = done_cnt;
      issue(1'b0, 8'h12, 8'h80);
      repeat (62 * 46 + 30) @(posedge clk);
      #5;
      chk("pre_rst_sioc", sioc, 0);
      chk("pre_rst_siod_drive_low", siod_drive_low, 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_sioc", sioc, 1);
      chk("mid_rst_siod_drive_low", siod_drive_low, 0);
      chk("mid_rst_cmd_ready", cmd_ready, 1);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (5000) @(posedge clk);
      #1;
      chk("no_done_after_abort", done_cnt, base_done);
      push_wr(8'h11, 8'h22, 1'b0);
      issue(1'b0, 8'h11, 8'h22);
      wait_done(base_done + 1, 12000);

      // responder withholds the ack of the data byte
      inject_byte = 2;
      push_wr(8'h3A, 8'hC5, 1'b1);
      issue(1'b0, 8'h3A, 8'hC5);
      wait_done(base_done + 2, 12000);
      inject_byte = -1;
      push_wr(8'h3A, 8'h00, 1'b0);
      issue(1'b0, 8'h3A, 8'h00);
      wait_done(base_done + 3, 12000);

      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
